// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the HUB75 row driver: FSM states,
// pix_data field positions and a constant-friendly clog2.
package led_matrix_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4,
    DISPLAY  = 3'd5,
    BLANK    = 3'd6
  } state_t;

  // Field index within pix_data, counted in COLOR_DEPTH-wide slices from the LSB.
  localparam int FIELD_R0 = 5;
  localparam int FIELD_G0 = 4;
  localparam int FIELD_B0 = 3;
  localparam int FIELD_R1 = 2;
  localparam int FIELD_G1 = 1;
  localparam int FIELD_B1 = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcm_timer.sv
// Loadable down-counter timing one BCM display slot and producing the oe gate.
// With HUB75_BRIGHTNESS_EN defined, the gate is shortened by the brightness input.
module bcm_timer
  import led_matrix_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] len,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          done,
  output logic          first_gate,
  output logic          next_gate
);

  logic [TW-1:0] rem;
  logic [TW-1:0] len_r;
  logic [TW-1:0] thr_r;
  logic [TW-1:0] thr_in;
  logic [TW-1:0] elapsed;

`ifdef HUB75_BRIGHTNESS_EN
  logic [TW+7:0] prod;
  assign prod   = {8'd0, len} * {{TW{1'b0}}, brightness};
  assign thr_in = prod[TW+7:8];
`else
  assign thr_in = len;
`endif

  // Gate for tick 0 is decided while loading; later ticks compare the next index.
  assign first_gate = (thr_in != {TW{1'b0}});
  assign elapsed    = len_r - rem;
  assign next_gate  = ((elapsed + {{(TW-1){1'b0}}, 1'b1}) < thr_r);
  assign done       = (rem == {{(TW-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem   <= {TW{1'b0}};
      len_r <= {TW{1'b0}};
      thr_r <= {TW{1'b0}};
    end else if (load) begin
      rem   <= len;
      len_r <= len;
      thr_r <= thr_in;
    end else if (rem != {TW{1'b0}}) begin
      rem   <= rem - {{(TW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 panel driver: re-streams each line once per bitplane and shows plane p
// for BASE_TICKS<<p cycles. Optional HUB75_BRIGHTNESS_EN adds a brightness input.
module hub75_row_driver
  import led_matrix_pkg::*;
#(
  parameter int PIXELS_PER_ROW = 64,
  parameter int LINES          = 32,
  parameter int COLOR_DEPTH    = 8,
  parameter int BASE_TICKS     = 4,
  localparam int LW = clog2(LINES),
  localparam int PW = clog2(COLOR_DEPTH),
  localparam int CW = clog2(PIXELS_PER_ROW),
  localparam int TW = clog2(BASE_TICKS << (COLOR_DEPTH - 1)) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]               brightness,
`endif
  output logic                     line_req,
  output logic [LW-1:0]            req_line,
  output logic [PW-1:0]            req_plane,
  input  logic [6*COLOR_DEPTH-1:0] pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     r0,
  output logic                     r1,
  output logic                     g0,
  output logic                     g1,
  output logic                     b0,
  output logic                     b1,
  output logic                     led_clk,
  output logic                     stb,
  output logic                     oe,
  output logic [LW-1:0]            line_select,
  output logic                     frame_done
);

  localparam logic [CW-1:0] LAST_COL   = CW'(PIXELS_PER_ROW - 1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(LINES - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(COLOR_DEPTH - 1);

  state_t                 state;
  logic [CW-1:0]          col;
  logic [COLOR_DEPTH-1:0] ch_r0, ch_g0, ch_b0, ch_r1, ch_g1, ch_b1;
  logic [TW-1:0]          plane_len;
  logic                   timer_load, timer_done, first_gate, next_gate;
  logic [LW-1:0]          adv_line;
  logic [PW-1:0]          adv_plane;
  logic                   wrap;

  assign ch_r0 = pix_data[FIELD_R0*COLOR_DEPTH +: COLOR_DEPTH];
  assign ch_g0 = pix_data[FIELD_G0*COLOR_DEPTH +: COLOR_DEPTH];
  assign ch_b0 = pix_data[FIELD_B0*COLOR_DEPTH +: COLOR_DEPTH];
  assign ch_r1 = pix_data[FIELD_R1*COLOR_DEPTH +: COLOR_DEPTH];
  assign ch_g1 = pix_data[FIELD_G1*COLOR_DEPTH +: COLOR_DEPTH];
  assign ch_b1 = pix_data[FIELD_B1*COLOR_DEPTH +: COLOR_DEPTH];

  assign plane_len  = TW'(BASE_TICKS) << req_plane;
  assign timer_load = (state == LATCH);

  bcm_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .len        (plane_len),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .done       (timer_done),
    .first_gate (first_gate),
    .next_gate  (next_gate)
  );

  // Next (line, plane) after the current bitplane; wrap flags end of frame.
  always_comb begin
    adv_line  = req_line;
    adv_plane = req_plane;
    wrap      = 1'b0;
    if (req_plane == LAST_PLANE) begin
      adv_plane = {PW{1'b0}};
      if (req_line == LAST_LINE) begin
        adv_line = {LW{1'b0}};
        wrap     = 1'b1;
      end else begin
        adv_line = req_line + LW'(1);
      end
    end else begin
      adv_plane = req_plane + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      col         <= {CW{1'b0}};
      line_req    <= 1'b0;
      req_line    <= {LW{1'b0}};
      req_plane   <= {PW{1'b0}};
      pix_ready   <= 1'b0;
      {r0, g0, b0, r1, g1, b1} <= 6'b000000;
      led_clk     <= 1'b0;
      stb         <= 1'b0;
      oe          <= 1'b1;
      line_select <= {LW{1'b0}};
      frame_done  <= 1'b0;
    end else begin
      line_req   <= 1'b0;
      stb        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          oe        <= 1'b1;
          led_clk   <= 1'b0;
          pix_ready <= 1'b0;
          if (en) begin
            req_line  <= {LW{1'b0}};
            req_plane <= {PW{1'b0}};
            line_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          col       <= {CW{1'b0}};
          pix_ready <= 1'b1;
          state     <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (pix_valid) begin
            r0        <= ch_r0[req_plane];
            g0        <= ch_g0[req_plane];
            b0        <= ch_b0[req_plane];
            r1        <= ch_r1[req_plane];
            g1        <= ch_g1[req_plane];
            b1        <= ch_b1[req_plane];
            led_clk   <= 1'b1;
            pix_ready <= 1'b0;
            state     <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          led_clk <= 1'b0;
          col     <= col + CW'(1);
          if (col == LAST_COL) begin
            stb         <= 1'b1;
            line_select <= req_line;
            state       <= LATCH;
          end else begin
            pix_ready <= 1'b1;
            state     <= SHIFT_LO;
          end
        end
        LATCH: begin
          oe    <= ~first_gate;
          state <= DISPLAY;
        end
        DISPLAY: begin
          if (timer_done) begin
            oe    <= 1'b1;
            state <= BLANK;
          end else begin
            oe <= ~next_gate;
          end
        end
        BLANK: begin
          frame_done <= wrap;
          if (en) begin
            req_line  <= adv_line;
            req_plane <= adv_plane;
            line_req  <= 1'b1;
            state     <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          oe        <= 1'b1;
          led_clk   <= 1'b0;
          pix_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_row_driver.sv
// Directed bench for hub75_row_driver with a 4-column, 2-line, 2-plane panel.
module tb_hub75_row_driver;

  localparam int PPR = 4;
  localparam int NL  = 2;
  localparam int CD  = 2;
  localparam int BT  = 3;

  logic            clk = 1'b0;
  logic            reset, en, pix_valid;
  logic [6*CD-1:0] pix_data;
  logic            line_req, pix_ready, r0, r1, g0, g1, b0, b1;
  logic            led_clk, stb, oe, frame_done;
  logic [0:0]      req_line, req_plane, line_select;

  int total = 0;
  int bad   = 0;
  int k;
  logic [1:0] kb;

  // Upstream pixel k carries r0 = k[1:0] and b1 = ~k[1:0].
  assign kb       = k[1:0];
  assign pix_data = {kb, 8'h00, ~kb};

  always #5 clk = ~clk;

  hub75_row_driver #(
    .PIXELS_PER_ROW(PPR), .LINES(NL), .COLOR_DEPTH(CD), .BASE_TICKS(BT)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .line_req(line_req), .req_line(req_line), .req_plane(req_plane),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .r0(r0), .r1(r1), .g0(g0), .g1(g1), .b0(b0), .b1(b1),
    .led_clk(led_clk), .stb(stb), .oe(oe),
    .line_select(line_select), .frame_done(frame_done)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else if (line_req) k <= 0;
    else if (pix_valid && pix_ready) k <= k + 1;
  end

  logic [1:0] req_q[$];
  logic       r0_q[$];
  logic       b1_q[$];
  logic       ls_q[$];
  int         oe_runs[$];
  int         run_len = 0;
  int         stb_cyc = 0;
  int         overlap = 0;
  int         frame_cnt = 0;
  logic       prev_clk = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      run_len  = 0;
      prev_clk = 1'b0;
    end else begin
      if (led_clk && !prev_clk) begin
        r0_q.push_back(r0);
        b1_q.push_back(b1);
      end
      prev_clk = led_clk;
      if (line_req) req_q.push_back({req_line, req_plane});
      if (!oe) begin
        if (run_len == 0) ls_q.push_back(line_select[0]);
        run_len++;
      end else if (run_len > 0) begin
        oe_runs.push_back(run_len);
        run_len = 0;
      end
      if (stb) stb_cyc++;
      if (stb && !oe) overlap++;
      if (frame_done) frame_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    req_q.delete(); r0_q.delete(); b1_q.delete(); ls_q.delete(); oe_runs.delete();
    stb_cyc = 0; overlap = 0; frame_cnt = 0;
  endtask

  logic [31:0] seq;
  int          stall_bad;
  int          n;

  initial begin
    reset = 1'b1; en = 1'b0; pix_valid = 1'b0;
    repeat (3) step();
    check("reset_pins", {20'd0, oe, led_clk, stb, line_req, pix_ready, frame_done,
                         r0, r1, g0, g1, b0, b1}, 32'h800);
    check("reset_addr", {29'd0, line_select, req_line, req_plane}, 32'h0);

    reset = 1'b0;
    repeat (5) step();
    check("idle_no_req", {31'd0, oe}, 32'h1);
    check("idle_req_cnt", req_q.size(), 32'd0);

    // Full frame with pix_valid always high.
    en = 1'b1; pix_valid = 1'b1;
    n = 0;
    while (frame_cnt == 0 && n < 300) begin step(); n++; end
    check("frame_done_seen", {31'd0, (frame_cnt > 0)}, 32'h1);
    repeat (3) step();
    en = 1'b0;  // drop enable while the next line is shifting plane 0
    repeat (60) step();

    check("req_count", req_q.size(), 32'd5);
    seq = '0;
    for (int i = 0; i < 5; i++) seq = {seq[29:0], (i < req_q.size()) ? req_q[i] : 2'bxx};
    check("req_sequence", seq, 32'h06C);
    seq = '0;
    for (int i = 0; i < 8; i++) seq = {seq[30:0], (i < r0_q.size()) ? r0_q[i] : 1'bx};
    check("r0_planes01", seq, 32'h53);
    check("edge_count", r0_q.size(), 32'd20);
    seq = '0;
    for (int i = 0; i < 4; i++) seq = {seq[30:0], (i < b1_q.size()) ? b1_q[i] : 1'bx};
    check("b1_plane0", seq, 32'hA);
    seq = '0;
    for (int i = 0; i < 5; i++) seq = {seq[27:0], (i < oe_runs.size()) ? oe_runs[i][3:0] : 4'hF};
    check("oe_runs", seq, 32'h36363);
    seq = '0;
    for (int i = 0; i < 5; i++) seq = {seq[30:0], (i < ls_q.size()) ? ls_q[i] : 1'bx};
    check("line_select", seq, 32'h06);
    check("stb_cycles", stb_cyc, 32'd5);
    check("stb_oe_overlap", overlap, 32'd0);
    check("frame_done_cnt", frame_cnt, 32'd1);
    check("idle_after_dis", {30'd0, oe, led_clk}, 32'h2);

    // Stall: pix_valid low for 5 cycles around column 2.
    clear_queues();
    en = 1'b1; pix_valid = 1'b1;
    n = 0;
    while (k != 2 && n < 50) begin step(); n++; end
    check("reach_col2", k, 32'd2);
    pix_valid = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (led_clk !== 1'b0 || r0 !== 1'b1) stall_bad++;
    end
    check("stall_hold", stall_bad, 32'd0);
    pix_valid = 1'b1;
    n = 0;
    while (oe !== 1'b0 && n < 100) begin step(); n++; end
    check("stall_display", {31'd0, oe}, 32'h0);
    check("stall_edges", r0_q.size(), 32'd4);
    seq = '0;
    for (int i = 0; i < 4; i++) seq = {seq[30:0], (i < r0_q.size()) ? r0_q[i] : 1'bx};
    check("stall_r0", seq, 32'h5);

    // Asynchronous reset in DISPLAY, checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_pins", {20'd0, oe, led_clk, stb, line_req, pix_ready, frame_done,
                         r0, r1, g0, g1, b0, b1}, 32'h800);
    check("async_addr", {29'd0, line_select, req_line, req_plane}, 32'h0);
    step();
    step();
    clear_queues();
    reset = 1'b0;
    n = 0;
    while (req_q.size() == 0 && n < 20) begin step(); n++; end
    check("post_reset_req", (req_q.size() > 0) ? {30'd0, req_q[0]} : 32'hFFFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_row_driver.md
Name: hub75_row_driver

Overview:
- Downstream physical stage of the LED matrix path. It consumes a stream of pixel pairs (upper half and lower half) from the row line buffer and drives the HUB75 panel pins: r0/r1/g0/g1/b0/b1, led_clk, stb, oe and line_select.
- Binary-code modulation (BCM): each line is re-streamed once per bitplane. Bitplane p is displayed for BASE_TICKS<<p cycles.
- Sits between the led_matrix_controller line buffer and the top-level panel IO.

Parameters:
- PIXELS_PER_ROW, 64: columns shifted per line (≥2).
- LINES, 32: multiplexed lines; line_select width is clog2(LINES).
- COLOR_DEPTH, 8: bits per colour channel, equal to the number of bitplanes.
- BASE_TICKS, 4: display cycles for bitplane 0 (≥1).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- en, in, 1: run enable.
- line_req, out, 1: one-cycle request for upstream to stream line req_line, bitplane req_plane.
- req_line, out, clog2(LINES): line being requested.
- req_plane, out, clog2(COLOR_DEPTH): bitplane being requested.
- pix_data, in, 6*COLOR_DEPTH: {r0,g0,b0,r1,g1,b1}, each COLOR_DEPTH bits, MSB first.
- pix_valid, in, 1: pix_data valid.
- pix_ready, out, 1: driver accepts a pixel when pix_valid&pix_ready.
- r0, r1, g0, g1, b0, b1, out, 1 each: colour bits of the current bitplane.
- led_clk, out, 1: panel shift clock; the panel samples on the rising edge.
- stb, out, 1: latch strobe, active high.
- oe, out, 1: output enable, active low (1 = blanked).
- line_select, out, clog2(LINES): panel line address.
- frame_done, out, 1: one-cycle pulse after the last plane of the last line.

Behaviour:
- Reset values:
  - State IDLE.
  - oe=1.
  - All other outputs 0, including led_clk, stb, line_req, pix_ready, frame_done, rgb, line_select, req_line, req_plane.
- Reset is asynchronous: asserting it at any time forces the reset values immediately.
- FSM states: IDLE, REQ, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY, BLANK.
- IDLE:
  - Holds oe=1.
  - When en=1, go to REQ with line=0, plane=0.
- REQ:
  - line_req=1 for exactly one cycle; req_line and req_plane are stable from this cycle until the next REQ.
  - Column counter cleared. Next state is SHIFT_LO.
- SHIFT_LO:
  - led_clk=0 and pix_ready=1.
  - On pix_valid, register rgb outputs as bit [plane] of each channel, then go to SHIFT_HI.
  - If pix_valid is low, stay with led_clk low and rgb held.
- SHIFT_HI:
  - led_clk=1 and pix_ready=0; rgb held.
  - Column counter increments. If it was PIXELS_PER_ROW-1, go to LATCH; otherwise go to SHIFT_LO.
  - One column costs at least 2 cycles.
- LATCH:
  - oe=1, stb=1 for one cycle, line_select<=line.
  - line_select changes only while oe=1.
- DISPLAY:
  - oe=0 for exactly BASE_TICKS<<plane cycles.
  - The tick counter is clog2(BASE_TICKS<<(COLOR_DEPTH-1))+1 bits wide, with no overflow.
- BLANK: oe=1 for one cycle, then advance:
  - If plane<COLOR_DEPTH-1: plane+1.
  - Else plane=0 and line+1.
  - On line wrap (LINES-1 → 0): pulse frame_done.
  - Then go to REQ if en=1, else IDLE.
- en=0 mid-line: the current plane completes through BLANK, then the FSM goes to IDLE. No partial shift is left latched.
- pix_valid while not in SHIFT_LO is ignored and is not consumed.
- oe is 0 only in DISPLAY; stb is 1 only in LATCH.

Optional Feature:
- HUB75_BRIGHTNESS_EN adds input brightness[7:0].
- In DISPLAY, oe=0 only while tick < ((BASE_TICKS<<plane)*brightness)>>8. oe=1 for the remaining ticks; total DISPLAY length is unchanged.
- brightness is sampled in LATCH.
- brightness=0 keeps the panel blank throughout.
- Without the macro, the port is absent and oe=0 for the full DISPLAY period.

Decomposition:
- Shared package (led_matrix_pkg): state enum, pixel-field offset constants for the pix_data slices, clog2 helper.
- One natural sub-module: bcm_timer (loadable down-counter producing done and the oe gate, including the brightness compare), instantiated once.

Test Plan:
- Basic line, with PIXELS_PER_ROW=4, LINES=2, COLOR_DEPTH=2, BASE_TICKS=3, en=1 and pix_valid always 1, upstream sending pixel k with r0 = k[1:0]:
  - Plane 0 shows r0 = 0,1,0,1 on the four led_clk rising edges.
  - stb is high for 1 cycle, then oe=0 for exactly 3 cycles.
  - Plane 1 shows r0 = 0,0,1,1, then oe=0 for 6 cycles.
- Frame: the same config run for 2 lines → line_req issued 4 times with (line,plane) = (0,0),(0,1),(1,0),(1,1); frame_done pulses once after the 4th BLANK; line_select=1 during the second line.
- Stall: pix_valid low for 5 cycles during column 2 → led_clk stays 0 and rgb is held; the column count after resume is still 4 rising edges total.
- Disable: en dropped during SHIFT of plane 0 → the line finishes LATCH/DISPLAY/BLANK, then IDLE with oe=1 and no further line_req.
- Async reset asserted mid-DISPLAY → oe=1 and all other outputs 0 in the same cycle without a clock edge; after release, the first line_req carries (0,0).
- HUB75_BRIGHTNESS_EN with brightness=128, BASE_TICKS=4, plane 1 → DISPLAY lasts 8 cycles with oe=0 for the first 4 only.
